// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port data SRAM (active-low CEB/WEB/BWEB, 1-cycle read
//   latency) between two requesters: 0 = CPU-side AXI slave path,
//   1 = second bus master (e.g. DMA). Round-robin between requesters, with a
//   per-burst lock that is capped at MAX_BURST beats.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   req_i/we_i/addr_i/    per-requester beat request (held until gnt_i),
//   wdata_i/wstrb_i/last_i  write flag, byte address, data, strobes, last beat
//   gnt_i                 combinational beat accept
//   rvalid_i/rdata_i      registered read-return strobe, data straight from DO
//   CEB/WEB/BWEB/A/DI/DO  SRAM macro pins
module sram_port_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int AW        = 14
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          req_0,
  input  logic          we_0,
  input  logic [31:0]   addr_0,
  input  logic [31:0]   wdata_0,
  input  logic [3:0]    wstrb_0,
  input  logic          last_0,
  input  logic          req_1,
  input  logic          we_1,
  input  logic [31:0]   addr_1,
  input  logic [31:0]   wdata_1,
  input  logic [3:0]    wstrb_1,
  input  logic          last_1,
  output logic          gnt_0,
  output logic          gnt_1,
  output logic          rvalid_0,
  output logic          rvalid_1,
  output logic [31:0]   rdata_0,
  output logic [31:0]   rdata_1,
  output logic          CEB,
  output logic          WEB,
  output logic [3:0]    BWEB,
  output logic [AW-1:0] A,
  output logic [31:0]   DI,
  input  logic [31:0]   DO
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  // Beat index at which the lock is forcibly released.
  localparam logic [7:0] CAP = 8'(MAX_BURST - 1);

  state_t     state;
  logic       rr_ptr;
  logic [7:0] beat_cnt;
  logic [1:0] rd_pend;

  // Grant: lock owner only while locked; otherwise single request wins,
  // ties go to rr_ptr. Reset masks everything so the pins stay idle.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (!ARESET) begin
      unique case (state)
        IDLE: begin
          if (req_0 && req_1) begin
            gnt_0 = ~rr_ptr;
            gnt_1 = rr_ptr;
          end else begin
            gnt_0 = req_0;
            gnt_1 = req_1;
          end
        end
        LOCK0:   gnt_0 = req_0;
        LOCK1:   gnt_1 = req_1;
        default: ;
      endcase
    end
  end

  // Selected requester's beat (index = gnt_1; only meaningful when granted).
  logic        any_gnt;
  logic        we_s;
  logic        last_s;
  logic [31:0] addr_s;
  logic [31:0] wdata_s;
  logic [3:0]  wstrb_s;

  assign any_gnt = gnt_0 | gnt_1;
  assign we_s    = gnt_1 ? we_1    : we_0;
  assign last_s  = gnt_1 ? last_1  : last_0;
  assign addr_s  = gnt_1 ? addr_1  : addr_0;
  assign wdata_s = gnt_1 ? wdata_1 : wdata_0;
  assign wstrb_s = gnt_1 ? wstrb_1 : wstrb_0;

  // Byte offset and high address bits never reach the word-addressed macro.
  logic unused_addr;
  assign unused_addr = ^{addr_s[31:AW+2], addr_s[1:0]};

  // SRAM pins: parked at inactive values whenever nothing is granted.
  always_comb begin
    CEB  = 1'b1;
    WEB  = 1'b1;
    BWEB = 4'hF;
    A    = '0;
    DI   = '0;
    if (any_gnt) begin
      CEB  = 1'b0;
      WEB  = ~we_s;
      BWEB = we_s ? ~wstrb_s : 4'hF;
      A    = addr_s[AW+1:2];
      DI   = wdata_s;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      beat_cnt <= 8'd0;
      rd_pend  <= 2'b00;
    end else begin
      rd_pend <= {gnt_1 & ~we_1, gnt_0 & ~we_0};
      if (any_gnt) begin
        if (last_s || beat_cnt == CAP) begin
          state    <= IDLE;
          rr_ptr   <= gnt_0;     // hand preference to the other requester
          beat_cnt <= 8'd0;
        end else begin
          state    <= gnt_1 ? LOCK1 : LOCK0;
          beat_cnt <= beat_cnt + 8'd1;
        end
      end
    end
  end

  assign rvalid_0 = rd_pend[0];
  assign rvalid_1 = rd_pend[1];
  assign rdata_0  = DO;
  assign rdata_1  = DO;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a default-size instance backed by a
// behavioural SRAM, plus a MAX_BURST=4 instance sharing the same requester
// inputs for the lock-cap case.
module tb_sram_port_arbiter;
  localparam int AW = 14;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          req_0, we_0, last_0, req_1, we_1, last_1;
  logic [31:0]   addr_0, wdata_0, addr_1, wdata_1;
  logic [3:0]    wstrb_0, wstrb_1;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [31:0]   rdata_0, rdata_1;
  logic          CEB, WEB;
  logic [3:0]    BWEB;
  logic [AW-1:0] A;
  logic [31:0]   DI;
  logic [31:0]   DO;

  logic          c_gnt_0, c_gnt_1, c_rvalid_0, c_rvalid_1;
  logic [31:0]   c_rdata_0, c_rdata_1;
  logic          c_CEB, c_WEB;
  logic [3:0]    c_BWEB;
  logic [AW-1:0] c_A;
  logic [31:0]   c_DI;
  logic [31:0]   c_DO = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  always #5 ACLK = ~ACLK;

  sram_port_arbiter #(.MAX_BURST(16), .AW(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .wstrb_0(wstrb_0), .last_0(last_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .wstrb_1(wstrb_1), .last_1(last_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
  );

  sram_port_arbiter #(.MAX_BURST(4), .AW(AW)) dut_cap (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .wstrb_0(wstrb_0), .last_0(last_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .wstrb_1(wstrb_1), .last_1(last_1),
    .gnt_0(c_gnt_0), .gnt_1(c_gnt_1), .rvalid_0(c_rvalid_0), .rvalid_1(c_rvalid_1),
    .rdata_0(c_rdata_0), .rdata_1(c_rdata_1),
    .CEB(c_CEB), .WEB(c_WEB), .BWEB(c_BWEB), .A(c_A), .DI(c_DI), .DO(c_DO)
  );

  // Behavioural single-port SRAM, active-low controls, 1-cycle read.
  always @(posedge ACLK) begin
    logic [31:0] w;
    if (!CEB) begin
      if (!WEB) begin
        w = mem[A];
        for (int b = 0; b < 4; b++)
          if (!BWEB[b]) w[8*b +: 8] = DI[8*b +: 8];
        mem[A] <= w;
      end else begin
        DO <= mem[A];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic l);
    req_0 = r; we_0 = w; addr_0 = a; wdata_0 = d; wstrb_0 = s; last_0 = l;
  endtask

  task automatic set1(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic l);
    req_1 = r; we_1 = w; addr_1 = a; wdata_1 = d; wstrb_1 = s; last_1 = l;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem[4] = 32'hCAFE_F00D;
    mem[5] = 32'h5555_AAAA;
    mem[8] = 32'h1122_3344;
    DO     = 32'h0;
    ARESET = 1'b1;
    set0(0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // Reset masks grants and parks the pins even with a write request up.
    set0(1, 1, 32'h10, 32'hFFFF_FFFF, 4'hF, 1); #2;
    chk("rst_gnt0", 32'(gnt_0), 0);
    chk("rst_ceb",  32'(CEB),   1);
    chk("rst_web",  32'(WEB),   1);
    chk("rst_bweb", 32'(BWEB),  32'hF);
    chk("rst_a",    32'(A),     0);
    chk("rst_di",   DI,         0);
    tick();
    ARESET = 1'b0;
    set0(0, 0, 0, 0, 0, 0);
    chk("rst_rv0", 32'(rvalid_0), 0);
    chk("rst_rv1", 32'(rvalid_1), 0);

    // Single read from word 4.
    set0(1, 0, 32'h10, 0, 0, 1); #2;
    chk("rd_gnt0", 32'(gnt_0), 1);
    chk("rd_gnt1", 32'(gnt_1), 0);
    chk("rd_ceb",  32'(CEB),   0);
    chk("rd_web",  32'(WEB),   1);
    chk("rd_a",    32'(A),     4);
    tick();
    set0(0, 0, 0, 0, 0, 0);
    chk("rd_rv0",   32'(rvalid_0), 1);
    chk("rd_rdata", rdata_0, 32'hCAFE_F00D);

    // Contention, rr_ptr=1 after the single read: 1,0,1,0.
    for (int k = 0; k < 4; k++) begin
      logic e1;
      e1 = (k % 2 == 0);
      set0(1, 0, 32'h10, 0, 0, 1);
      set1(1, 0, 32'h14, 0, 0, 1); #2;
      chk("cont_gnt1", 32'(gnt_1), 32'(e1));
      chk("cont_gnt0", 32'(gnt_0), 32'(!e1));
      chk("cont_ceb",  32'(CEB),   0);
      tick();
      chk("cont_rv1",   32'(rvalid_1), 32'(e1));
      chk("cont_rv0",   32'(rvalid_0), 32'(!e1));
      chk("cont_rdata", rdata_1, e1 ? 32'h5555_AAAA : 32'hCAFE_F00D);
    end
    set0(0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0);

    // Burst lock: 4 beats from requester 0, with a bubble where req_0 drops.
    set0(1, 0, 32'h10, 0, 0, 0); #2;
    chk("bl_b1_gnt0", 32'(gnt_0), 1);
    tick();
    set1(1, 0, 32'h14, 0, 0, 1); #2;
    chk("bl_b2_gnt0", 32'(gnt_0), 1);
    chk("bl_b2_gnt1", 32'(gnt_1), 0);
    tick();
    set0(0, 0, 0, 0, 0, 0); #2;
    chk("bl_gap_gnt1", 32'(gnt_1), 0);
    chk("bl_gap_gnt0", 32'(gnt_0), 0);
    chk("bl_gap_ceb",  32'(CEB),   1);
    chk("bl_gap_rv0",  32'(rvalid_0), 1);
    tick();
    chk("bl_gap_rv0_off", 32'(rvalid_0), 0);
    set0(1, 0, 32'h10, 0, 0, 0); #2;
    chk("bl_b3_gnt0", 32'(gnt_0), 1);
    chk("bl_b3_gnt1", 32'(gnt_1), 0);
    tick();
    set0(1, 0, 32'h10, 0, 0, 1); #2;
    chk("bl_b4_gnt0", 32'(gnt_0), 1);
    chk("bl_b4_gnt1", 32'(gnt_1), 0);
    tick();
    set0(0, 0, 0, 0, 0, 0); #2;
    chk("bl_rel_gnt1", 32'(gnt_1), 1);
    tick();
    set1(0, 0, 0, 0, 0, 0);

    // Byte write 0xAABBCCDD, wstrb 0101, over 0x11223344, then read back.
    set0(1, 1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1); #2;
    chk("bw_gnt0", 32'(gnt_0), 1);
    chk("bw_web",  32'(WEB),   0);
    chk("bw_bweb", 32'(BWEB),  32'hA);
    chk("bw_a",    32'(A),     8);
    chk("bw_di",   DI,         32'hAABB_CCDD);
    tick();
    set0(1, 0, 32'h20, 0, 0, 1); #2;
    chk("bw_rd_gnt0", 32'(gnt_0), 1);
    tick();
    set0(0, 0, 0, 0, 0, 0);
    chk("bw_rv0",    32'(rvalid_0), 1);
    chk("bw_rdata",  rdata_0, 32'h11BB_33DD);

    // Zero-strobe write from requester 1 is issued but changes nothing.
    set1(1, 1, 32'h20, 32'h0, 4'h0, 1); #2;
    chk("zs_gnt1", 32'(gnt_1), 1);
    chk("zs_web",  32'(WEB),   0);
    chk("zs_bweb", 32'(BWEB),  32'hF);
    tick();
    set1(1, 0, 32'h20, 0, 0, 1); #2;
    chk("zs_rd_gnt1", 32'(gnt_1), 1);
    tick();
    set1(0, 0, 0, 0, 0, 0);
    chk("zs_rv1",   32'(rvalid_1), 1);
    chk("zs_rv0",   32'(rvalid_0), 0);
    chk("zs_rdata", rdata_1, 32'h11BB_33DD);

    // Reset in LOCK1 with a read pending.
    set1(1, 0, 32'h14, 0, 0, 0); #2;
    chk("rl_b1_gnt1", 32'(gnt_1), 1);
    tick();
    chk("rl_pre_rv1", 32'(rvalid_1), 1);
    ARESET = 1'b1; #2;
    chk("rl_rst_gnt1", 32'(gnt_1), 0);
    chk("rl_rst_ceb",  32'(CEB),   1);
    tick();
    ARESET = 1'b0;
    set1(0, 0, 0, 0, 0, 0);
    chk("rl_post_rv1", 32'(rvalid_1), 0);
    set0(1, 0, 32'h10, 0, 0, 1);
    set1(1, 0, 32'h14, 0, 0, 1); #2;
    chk("rl_cont_gnt0", 32'(gnt_0), 1);
    chk("rl_cont_gnt1", 32'(gnt_1), 0);
    tick();
    set0(0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0);

    // Lock cap: MAX_BURST=4 instance releases after 4 beats; default keeps going.
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set0(1, 0, 32'h10, 0, 0, 0);
      set1(1, 0, 32'h14, 0, 0, 1); #2;
      chk("cap_gnt0",   32'(c_gnt_0), 1);
      chk("cap_gnt1",   32'(c_gnt_1), 0);
      chk("cap16_gnt0", 32'(gnt_0),   1);
      tick();
    end
    #2;
    chk("cap_rel_gnt1",   32'(c_gnt_1), 1);
    chk("cap_rel_gnt0",   32'(c_gnt_0), 0);
    chk("cap16_b5_gnt0",  32'(gnt_0),   1);
    chk("cap16_b5_gnt1",  32'(gnt_1),   0);
    tick();
    set0(0, 0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // At most one grant per cycle, and never without the matching request.
  always @(negedge ACLK) begin
    if (gnt_0 && gnt_1) begin
      errors++;
      $display("FAIL dual_gnt got 2 grants want at most 1");
    end
    if ((gnt_0 && !req_0) || (gnt_1 && !req_1)) begin
      errors++;
      $display("FAIL gnt_no_req got %b%b want subset of %b%b", gnt_1, gnt_0, req_1, req_0);
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter for a single-port data SRAM macro with active-low CEB/WEB/BWEB controls and 1-cycle read latency. It lets the CPU-side AXI slave path (requester 0) and a second bus master, such as a DMA engine (requester 1), share one SRAM. Arbitration is round-robin, with burst locking and a bounded lock length. It drives the macro's CEB/WEB/BWEB/A/D pins and returns Q to the granted requester with a matching valid strobe.

## Interface
Parameters:
- MAX_BURST, 16: maximum consecutive beats granted to one requester under lock; legal range 1..256.
- AW, 14: SRAM word-address width; A = addr_i[AW+1:2].

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- req_0 / req_1  in  1  access request, held until the matching gnt.
- we_0 / we_1  in  1  1 = write, 0 = read.
- addr_0 / addr_1  in  32  byte address; bits [1:0] are ignored.
- wdata_0 / wdata_1  in  32  write data.
- wstrb_0 / wstrb_1  in  4  active-high byte strobes.
- last_0 / last_1  in  1  marks the final beat of a burst; 1 on single accesses.
- gnt_0 / gnt_1  out  1  combinational; the beat is accepted this cycle.
- rvalid_0 / rvalid_1  out  1  registered; rdata is valid for the read granted in the previous cycle.
- rdata_0 / rdata_1  out  32  both driven from DO; meaningful only while the matching rvalid is high.
- CEB  out  1  SRAM chip enable, active-low.
- WEB  out  1  SRAM write enable, active-low.
- BWEB  out  4  per-byte write mask, active-low; the top level expands it to bit lanes.
- A  out  AW  SRAM word address.
- DI  out  32  SRAM write data.
- DO  in  32  SRAM read data, valid one cycle after the read edge.

## Operation
- FSM states: IDLE, LOCK0, LOCK1. Registers: rr_ptr (1 b, the preferred requester), beat_cnt (8 b), rd_pend[1:0].
- Grant in IDLE:
  - If exactly one request is active, grant it.
  - If both are active, grant the requester selected by rr_ptr.
- Grant in LOCKi: only requester i can be granted. The other requester waits even if requester i drops req.
- Each accepted beat from i updates state:
  - If last_i = 1 or beat_cnt = MAX_BURST-1: go to IDLE, set rr_ptr = ~i, clear beat_cnt.
  - Otherwise: go to or stay in LOCKi and increment beat_cnt.
- With MAX_BURST = 1, every beat releases the lock.
- SRAM pins during a granted cycle:
  - CEB=0.
  - WEB=~we_i.
  - BWEB=~wstrb_i on writes, 4'hF on reads.
  - A=addr_i[AW+1:2].
  - DI=wdata_i.
- SRAM pins with no grant: CEB=1, WEB=1, BWEB=4'hF, A=0, DI=0.
- A write with wstrb=0 is still granted and issued with BWEB=4'hF, so no byte changes.
- Read return: rd_pend[i] <= gnt_i & ~we_i, and rvalid_i = rd_pend[i]. Back-to-back reads yield one rvalid per cycle.
- At most one gnt is high in any cycle; gnt is never asserted without the matching req.

## Timing
- Grant latency is 0 cycles from req in IDLE, or in LOCKi for the lock owner.
- Read latency is exactly 1 cycle from gnt to rvalid; rdata = DO in that cycle.
- A write takes effect at the edge that ends the gnt cycle. A read of the same word granted in the next cycle returns the new data.
- While ARESET is high:
  - gnt_0 = gnt_1 = 0.
  - CEB=1, WEB=1, BWEB=4'hF, A=0, DI=0.
- Registered outputs after the reset edge:
  - rvalid_0 = rvalid_1 = 0.
  - State = IDLE, rr_ptr = 0, beat_cnt = 0.
- Reset asserted mid-burst or with a read pending:
  - The lock is dropped.
  - The pending rvalid is suppressed, so no stale rvalid appears after reset.
- A lock holder that deasserts req keeps the lock. beat_cnt does not advance without a grant.

## Test plan
- Reset, then a single read: req_0 with addr 0x0000_0010 and last=1 -> gnt_0 the same cycle with A=4 and CEB=0. rvalid_0 is high the next cycle with rdata equal to the preloaded word. rr_ptr=1.
- Contention: req_0 and req_1 both high with last=1 for 4 cycles -> grants go 1,0,1,0 when rr_ptr starts at 1. CEB stays low throughout and at most one gnt is high per cycle.
- Burst lock: requester 0 issues a 4-beat burst (last on beat 4) while req_1 is held -> gnt_1 stays 0 for 4 grant cycles, then gnt_1 fires in the cycle after the last beat.
- MAX_BURST cap: MAX_BURST=4, requester 0 streams with last=0 and req_1 is held -> lock releases after 4 beats and gnt_1 fires next, with no fifth gnt_0 in between.
- Byte write: write 0xAABBCCDD with wstrb=4'b0101 over word 0x1122_3344 -> BWEB=4'b1010, and a read-back one cycle later returns 0x11BB_33DD.
- Reset during LOCK1 with a read pending: ARESET pulses for 1 cycle -> no rvalid_1 appears after the reset edge. The next contention grants requester 0 first because rr_ptr=0.
